// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // A single-bit counter is still needed when the operand is one bit wide.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder built from two half-adder gate stages and an OR gate.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;
  logic half_carry;
  logic prop_carry;

  xor x_ha0 (half_sum, a, b);
  and a_ha0 (half_carry, a, b);
  xor x_ha1 (sum, half_sum, cin);
  and a_ha1 (prop_carry, half_sum, cin);
  or  o_cy  (cout, half_carry, prop_carry);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one operand bit per cycle, result registered at DONE.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf_out.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             carry_msb;
`endif

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy_out = (state != IDLE);

  serial_fa_bit u_fa (
    .a    (a_reg[cnt]),
    .b    (b_reg[cnt]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so the first (LSB) bit ends up in bit 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      cout_out  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      carry_msb <= 1'b0;
      ovf_out   <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            a_reg <= a_in;
            b_reg <= b_in;
            carry <= cin_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          result <= {fa_sum, result[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
`ifdef SERIAL_ADD_OVF_EN
          if (last_bit) carry_msb <= carry;
`endif
        end
        DONE: begin
          sum_out  <= result;
          cout_out <= carry;
          done_out <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          ovf_out  <= carry_msb ^ carry;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table, corner sequences, random ops.
// Checks ovf_out only when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         start_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] sum_out;
  logic         cout_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (start_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .sum_out  (sum_out),
    .cout_out (cout_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_out  (ovf_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
    a_in     = a;
    b_in     = b;
    cin_in   = c;
    start_in = 1'b1;
  endtask

  // Called at a negedge with start asserted; returns at the negedge where done_out is seen.
  task automatic waitDone(output int lat, output int bcnt);
    @(posedge clk_in);
    #1 start_in = 1'b0;
    lat  = 0;
    bcnt = 0;
    @(negedge clk_in);
    if (busy_out) bcnt++;
    while (lat < 40) begin
      @(posedge clk_in);
      lat++;
      @(negedge clk_in);
      if (busy_out) bcnt++;
      if (done_out) break;
    end
  endtask

  task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int lat, output int bcnt);
    @(negedge clk_in);
    applyStimulus(a, b, c);
    waitDone(lat, bcnt);
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic logic [8:0] modelSum(input logic [7:0] a, input logic [7:0] b, input logic c);
    int total;
    total = int'(a) + int'(b) + int'(c);
    return 9'(total % 512);
  endfunction

  function automatic logic modelOvf(input logic [7:0] a, input logic [7:0] b, input logic c);
    int sa, sb, s;
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    s  = sa + sb + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  initial begin
    int lat, bcnt, dones;
    logic [7:0] cap_sum;
    logic       cap_cout;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] exp;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_in   = 1'b1;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    cin_in   = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    checkOutput("reset_busy", 32'(busy_out), 32'd0);
    checkOutput("reset_done", 32'(done_out), 32'd0);
    checkOutput("reset_sum", 32'(sum_out), 32'd0);
    checkOutput("reset_cout", 32'(cout_out), 32'd0);

    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd9);
      checkOutput($sformatf("vec%0d_sum", i), 32'(sum_out), 32'(vecs[i].sum));
      checkOutput($sformatf("vec%0d_cout", i), 32'(cout_out), 32'(vecs[i].cout));
`ifdef SERIAL_ADD_OVF_EN
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf_out), 32'(vecs[i].ovf));
`endif
      @(negedge clk_in);
      checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done_out), 32'd0);
      checkOutput($sformatf("vec%0d_sum_hold", i), 32'(sum_out), 32'(vecs[i].sum));
    end

    // Start held high and operands scrambled during RUN.
    @(negedge clk_in);
    applyStimulus(8'h12, 8'h34, 1'b1);
    @(posedge clk_in);
    dones    = 0;
    cap_sum  = '0;
    cap_cout = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (i < 8) begin
        a_in   = 8'($urandom);
        b_in   = 8'($urandom);
        cin_in = 1'($urandom);
        if (i > 0) checkOutput("hold_sum_stable_run", 32'(sum_out), 32'h00);
      end else begin
        start_in = 1'b0;
      end
      if (done_out) begin
        dones++;
        cap_sum  = sum_out;
        cap_cout = cout_out;
      end
    end
    checkOutput("hold_done_count", 32'(dones), 32'd1);
    checkOutput("hold_sum", 32'(cap_sum), 32'h47);
    checkOutput("hold_cout", 32'(cap_cout), 32'd0);

    // Reset in the middle of RUN, with start asserted on the reset edge.
    @(negedge clk_in);
    applyStimulus(8'hC3, 8'h5A, 1'b0);
    @(posedge clk_in);
    #1 start_in = 1'b0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    rst_in   = 1'b1;
    start_in = 1'b1;
    @(negedge clk_in);
    rst_in   = 1'b0;
    start_in = 1'b0;
    checkOutput("abort_busy", 32'(busy_out), 32'd0);
    checkOutput("abort_sum", 32'(sum_out), 32'd0);
    checkOutput("abort_cout", 32'(cout_out), 32'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      if (done_out || busy_out) dones++;
    end
    checkOutput("abort_no_activity", 32'(dones), 32'd0);
    runOp(8'h10, 8'h20, 1'b0, lat, bcnt);
    checkOutput("abort_next_latency", 32'(lat), 32'd9);
    checkOutput("abort_next_sum", 32'(sum_out), 32'h30);

    // Back-to-back: second start in the IDLE cycle right after DONE.
    @(negedge clk_in);
    runOp(8'h21, 8'h43, 1'b0, lat, bcnt);
    checkOutput("b2b_first_sum", 32'(sum_out), 32'h64);
    applyStimulus(8'hF0, 8'h20, 1'b1);
    waitDone(lat, bcnt);
    checkOutput("b2b_done_gap", 32'(lat + 1), 32'd10);
    checkOutput("b2b_second_sum", 32'(sum_out), 32'h11);
    checkOutput("b2b_second_cout", 32'(cout_out), 32'd1);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom_range(1, 0));
      exp = modelSum(ra, rb, rc);
      runOp(ra, rb, rc, lat, bcnt);
      checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'd9);
      checkOutput($sformatf("rand%0d_sum", i), 32'(sum_out), 32'(exp[7:0]));
      checkOutput($sformatf("rand%0d_cout", i), 32'(cout_out), 32'(exp[8]));
`ifdef SERIAL_ADD_OVF_EN
      checkOutput($sformatf("rand%0d_ovf", i), 32'(ovf_out), 32'(modelOvf(ra, rb, rc)));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
